// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//    Raster timing source for the sprite/background renderers. It produces
//    the pixel coordinates, the active-video qualifier, the sync pulses and
//    the line/frame markers used by the game logic.
//
// Ports
//    vga_clk      in   pixel clock
//    reset        in   asynchronous, active-high reset
//    ce           in   pixel advance enable (tie high for a 1x pixel clock)
//    DrawX        out  [9:0] horizontal position, 0..H_TOTAL-1
//    DrawY        out  [9:0] vertical position, 0..V_TOTAL-1
//    blank        out  1 = active video; renderers drive colour only when 1
//    hs           out  horizontal sync, active-low
//    vs           out  vertical sync, active-low
//    sync         out  composite sync, tied to 0
//    line_start   out  one enabled-cycle pulse when DrawX has wrapped to 0
//    frame_start  out  one enabled-cycle pulse when (DrawX,DrawY) wrapped to (0,0)
//
// hs/vs/blank are registered and derived from the next counter values, so
// they line up with DrawX/DrawY on the same cycle. The encoder adds the one
// cycle of delay that matches the renderers' registered colour.

module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       ce,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       sync,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Both totals must fit the 10-bit counters.
   if (H_TOTAL > 1024) begin : g_h_total_too_big
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
   end
   if (V_TOTAL > 1024) begin : g_v_total_too_big
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
   end

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   // Window bounds are 11 bits wide so an end bound of exactly 1024 still fits.
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
   localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       blank_q, blank_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;

   logic       x_wrap;
   logic       y_wrap;
   logic [10:0] x_ext;
   logic [10:0] y_ext;

   always_comb begin
      x_wrap = (x_q == H_LAST);
      y_wrap = (y_q == V_LAST);

      x_d = x_q;
      y_d = y_q;
      if (ce) begin
         if (x_wrap) begin
            x_d = 10'd0;
            y_d = y_wrap ? 10'd0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end

      // Decoding the next counter values keeps these aligned with DrawX/DrawY;
      // with ce low x_d/y_d equal the current values, so the outputs hold.
      x_ext   = {1'b0, x_d};
      y_ext   = {1'b0, y_d};
      blank_d = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
      hs_d    = !((x_ext >= HS_START) && (x_ext < HS_END));
      vs_d    = !((y_ext >= VS_START) && (y_ext < VS_END));

      // Pulses exist only on an enabled cycle that performs the wrap.
      line_start_d  = ce && x_wrap;
      frame_start_d = ce && x_wrap && y_wrap;
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         blank_q       <= 1'b1;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         blank_q       <= blank_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign DrawX       = x_q;
   assign DrawY       = y_q;
   assign blank       = blank_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign sync        = 1'b0;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//    Scoreboard bench for vga_timing_gen. Three instances share one clock:
//       inst 0: default 640x480 timing
//       inst 1: 320/8/48/24 x 240/5/1/16 (H_TOTAL 400, V_TOTAL 262)
//       inst 2: 16/2/4/2 x 8/1/2/1 (24x12, 288-pixel frame) for frame-level checks
//    The reference model derives every output from the number of enabled
//    pixels since reset (position = n mod H_TOTAL etc.), independently of how
//    the design counts.

module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank;
      logic       hs;
      logic       vs;
      logic       sync;
      logic       ls;
      logic       fs;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_r [3];
   logic       ce_r  [3];
   logic [9:0] dx    [3];
   logic [9:0] dy    [3];
   logic       blank_o [3];
   logic       hs_o  [3];
   logic       vs_o  [3];
   logic       sync_o [3];
   logic       ls_o  [3];
   logic       fs_o  [3];

   int hv_p [3] = '{640, 320, 16};
   int hf_p [3] = '{16,  8,   2};
   int hs_p [3] = '{96,  48,  4};
   int hb_p [3] = '{48,  24,  2};
   int vv_p [3] = '{480, 240, 8};
   int vf_p [3] = '{10,  5,   1};
   int vs_p [3] = '{2,   1,   2};
   int vb_p [3] = '{33,  16,  1};

   int   n_cnt [3];
   obs_t sb_q [$];
   int   vec_cnt = 0;
   int   err_cnt = 0;

   vga_timing_gen u_def (
      .vga_clk(clk), .reset(rst_r[0]), .ce(ce_r[0]),
      .DrawX(dx[0]), .DrawY(dy[0]), .blank(blank_o[0]), .hs(hs_o[0]), .vs(vs_o[0]),
      .sync(sync_o[0]), .line_start(ls_o[0]), .frame_start(fs_o[0]));

   vga_timing_gen #(
      .H_VISIBLE(320), .H_FRONT(8), .H_SYNC(48), .H_BACK(24),
      .V_VISIBLE(240), .V_FRONT(5), .V_SYNC(1), .V_BACK(16)
   ) u_alt (
      .vga_clk(clk), .reset(rst_r[1]), .ce(ce_r[1]),
      .DrawX(dx[1]), .DrawY(dy[1]), .blank(blank_o[1]), .hs(hs_o[1]), .vs(vs_o[1]),
      .sync(sync_o[1]), .line_start(ls_o[1]), .frame_start(fs_o[1]));

   vga_timing_gen #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
      .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) u_tiny (
      .vga_clk(clk), .reset(rst_r[2]), .ce(ce_r[2]),
      .DrawX(dx[2]), .DrawY(dy[2]), .blank(blank_o[2]), .hs(hs_o[2]), .vs(vs_o[2]),
      .sync(sync_o[2]), .line_start(ls_o[2]), .frame_start(fs_o[2]));

   // Expected outputs after n enabled pixels; adv says whether the last edge advanced.
   function automatic obs_t model(int inst, int n, bit adv);
      obs_t r;
      int ht, vt, x, y, hss, vss;
      ht  = hv_p[inst] + hf_p[inst] + hs_p[inst] + hb_p[inst];
      vt  = vv_p[inst] + vf_p[inst] + vs_p[inst] + vb_p[inst];
      x   = n % ht;
      y   = (n / ht) % vt;
      hss = hv_p[inst] + hf_p[inst];
      vss = vv_p[inst] + vf_p[inst];
      r.x     = 10'(x);
      r.y     = 10'(y);
      r.blank = (x < hv_p[inst]) && (y < vv_p[inst]);
      r.hs    = !((x >= hss) && (x < hss + hs_p[inst]));
      r.vs    = !((y >= vss) && (y < vss + vs_p[inst]));
      r.sync  = 1'b0;
      r.ls    = adv && (n > 0) && (x == 0);
      r.fs    = adv && (n > 0) && (x == 0) && (y == 0);
      return r;
   endfunction

   function automatic obs_t get_obs(int inst);
      return {dx[inst], dy[inst], blank_o[inst], hs_o[inst], vs_o[inst],
              sync_o[inst], ls_o[inst], fs_o[inst]};
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("(x=%0d y=%0d blank=%0b hs=%0b vs=%0b sync=%0b ls=%0b fs=%0b)",
                       o.x, o.y, o.blank, o.hs, o.vs, o.sync, o.ls, o.fs);
   endfunction

   // Synchronous reset pulse; leaves the bench at a falling edge with n = 0.
   task automatic do_reset(int inst);
      rst_r[inst] = 1'b1;
      ce_r[inst]  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_r[inst] = 1'b0;
      n_cnt[inst] = 0;
   endtask

   // One clock with the given ce; pushes the expectation for the following falling edge.
   task automatic tick(int inst, bit c);
      ce_r[inst] = c;
      @(posedge clk);
      if (rst_r[inst]) n_cnt[inst] = 0;
      else if (c) n_cnt[inst] = n_cnt[inst] + 1;
      sb_q.push_back(model(inst, n_cnt[inst], c && !rst_r[inst]));
      @(negedge clk);
   endtask

   task automatic test_reset();
      obs_t exp, obs;
      do_reset(0);
      for (int i = 0; i < 5; i++) begin
         tick(0, 1'b1);
         exp = sb_q.pop_front(); obs = get_obs(0); vec_cnt++;
         if (obs !== exp) begin
            err_cnt++;
            $display("FAIL reset_pre i=%0d got %s need %s", i, fmt(obs), fmt(exp));
         end
      end
      // Asynchronous assertion: outputs must change before any clock edge.
      rst_r[0] = 1'b1;
      #1;
      n_cnt[0] = 0;
      sb_q.push_back(model(0, 0, 1'b0));
      exp = sb_q.pop_front(); obs = get_obs(0); vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL reset_async got %s need %s", fmt(obs), fmt(exp));
      end
      for (int i = 0; i < 2; i++) begin
         tick(0, 1'b1);
         exp = sb_q.pop_front(); obs = get_obs(0); vec_cnt++;
         if (obs !== exp) begin
            err_cnt++;
            $display("FAIL reset_hold i=%0d got %s need %s", i, fmt(obs), fmt(exp));
         end
      end
      rst_r[0] = 1'b0;
      tick(0, 1'b1);
      exp = sb_q.pop_front(); obs = get_obs(0); vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL reset_release got %s need %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_line_scan();
      obs_t exp, obs;
      int ls_cnt = 0, hs_low = 0, blank_low = 0, max_x = 0;
      do_reset(0);
      for (int i = 0; i < 1600; i++) begin
         tick(0, 1'b1);
         exp = sb_q.pop_front(); obs = get_obs(0); vec_cnt++;
         if (obs !== exp) begin
            err_cnt++;
            $display("FAIL line_scan n=%0d got %s need %s", n_cnt[0], fmt(obs), fmt(exp));
         end
         if (obs.ls) ls_cnt++;
         if (!obs.hs) hs_low++;
         if (!obs.blank) blank_low++;
         if (int'(obs.x) > max_x) max_x = int'(obs.x);
      end
      vec_cnt++;
      if (max_x !== 799) begin
         err_cnt++; $display("FAIL line_max_x got %0d need 799", max_x);
      end
      vec_cnt++;
      if (ls_cnt !== 2) begin
         err_cnt++; $display("FAIL line_start_count got %0d need 2", ls_cnt);
      end
      vec_cnt++;
      if (hs_low !== 192) begin
         err_cnt++; $display("FAIL hs_low_cycles got %0d need 192", hs_low);
      end
      vec_cnt++;
      if (blank_low !== 320) begin
         err_cnt++; $display("FAIL blank_low_cycles got %0d need 320", blank_low);
      end
   endtask

   task automatic test_frame();
      obs_t exp, obs;
      int fs_first = -1, fs_second = -1, vs_low = 0;
      do_reset(2);
      for (int i = 1; i <= 578; i++) begin
         tick(2, 1'b1);
         exp = sb_q.pop_front(); obs = get_obs(2); vec_cnt++;
         if (obs !== exp) begin
            err_cnt++;
            $display("FAIL frame n=%0d got %s need %s", n_cnt[2], fmt(obs), fmt(exp));
         end
         if (!obs.vs) vs_low++;
         if (obs.fs) begin
            if (fs_first < 0) fs_first = i;
            else if (fs_second < 0) fs_second = i;
         end
      end
      vec_cnt++;
      if (fs_second - fs_first !== 288) begin
         err_cnt++;
         $display("FAIL frame_period got %0d need 288", fs_second - fs_first);
      end
      vec_cnt++;
      if (vs_low !== 96) begin
         err_cnt++; $display("FAIL vs_low_cycles got %0d need 96", vs_low);
      end
   endtask

   task automatic test_ce_toggle();
      obs_t exp, obs;
      int fs_first = -1, fs_second = -1, fs_cnt = 0;
      do_reset(2);
      for (int i = 1; i <= 1160; i++) begin
         tick(2, (i % 2) == 1);
         exp = sb_q.pop_front(); obs = get_obs(2); vec_cnt++;
         if (obs !== exp) begin
            err_cnt++;
            $display("FAIL ce_toggle i=%0d got %s need %s", i, fmt(obs), fmt(exp));
         end
         if (obs.fs) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = i;
            else if (fs_second < 0) fs_second = i;
         end
      end
      ce_r[2] = 1'b0;
      vec_cnt++;
      if (fs_second - fs_first !== 576) begin
         err_cnt++;
         $display("FAIL ce_frame_period got %0d need 576", fs_second - fs_first);
      end
      vec_cnt++;
      if (fs_cnt !== 2) begin
         err_cnt++; $display("FAIL ce_fs_high_cycles got %0d need 2", fs_cnt);
      end
   endtask

   task automatic test_reset_mid();
      obs_t exp, obs;
      int fs_first = -1;
      do_reset(2);
      for (int i = 0; i < 130; i++) begin
         tick(2, 1'b1);
         exp = sb_q.pop_front(); obs = get_obs(2); vec_cnt++;
         if (obs !== exp) begin
            err_cnt++;
            $display("FAIL mid_run n=%0d got %s need %s", n_cnt[2], fmt(obs), fmt(exp));
         end
      end
      vec_cnt++;
      if (dx[2] !== 10'd10 || dy[2] !== 10'd5) begin
         err_cnt++;
         $display("FAIL mid_position got x=%0d y=%0d need x=10 y=5", dx[2], dy[2]);
      end
      rst_r[2] = 1'b1;
      #1;
      n_cnt[2] = 0;
      sb_q.push_back(model(2, 0, 1'b0));
      exp = sb_q.pop_front(); obs = get_obs(2); vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL mid_async got %s need %s", fmt(obs), fmt(exp));
      end
      tick(2, 1'b1);
      exp = sb_q.pop_front(); obs = get_obs(2); vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL mid_hold got %s need %s", fmt(obs), fmt(exp));
      end
      rst_r[2] = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         tick(2, 1'b1);
         exp = sb_q.pop_front(); obs = get_obs(2); vec_cnt++;
         if (obs !== exp) begin
            err_cnt++;
            $display("FAIL mid_restart i=%0d got %s need %s", i, fmt(obs), fmt(exp));
         end
         if (obs.fs && fs_first < 0) fs_first = i;
      end
      vec_cnt++;
      if (fs_first !== 288) begin
         err_cnt++; $display("FAIL mid_first_frame_start got %0d need 288", fs_first);
      end
   endtask

   task automatic test_alt_params();
      obs_t exp, obs;
      int max_x = 0, first_low = -1, hs_low = 0;
      do_reset(1);
      for (int i = 0; i < 810; i++) begin
         tick(1, 1'b1);
         exp = sb_q.pop_front(); obs = get_obs(1); vec_cnt++;
         if (obs !== exp) begin
            err_cnt++;
            $display("FAIL alt_params n=%0d got %s need %s", n_cnt[1], fmt(obs), fmt(exp));
         end
         if (int'(obs.x) > max_x) max_x = int'(obs.x);
         if (!obs.hs) begin
            hs_low++;
            if (first_low < 0) first_low = int'(obs.x);
         end
      end
      ce_r[1] = 1'b0;
      vec_cnt++;
      if (max_x !== 399) begin
         err_cnt++; $display("FAIL alt_max_x got %0d need 399", max_x);
      end
      vec_cnt++;
      if (first_low !== 328) begin
         err_cnt++; $display("FAIL alt_hs_first_x got %0d need 328", first_low);
      end
      vec_cnt++;
      if (hs_low !== 96) begin
         err_cnt++; $display("FAIL alt_hs_low_cycles got %0d need 96", hs_low);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_r[i] = 1'b1;
         ce_r[i]  = 1'b0;
         n_cnt[i] = 0;
      end
      @(negedge clk);
      test_reset();
      test_line_scan();
      test_frame();
      test_ce_toggle();
      test_reset_mid();
      test_alt_params();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
